// File: rtl/lcd_frame_reader.sv
// lcd_frame_reader
//   Frame-buffer read scheduler. Prefetches 96-bit words (4 x 24-bit BGR
//   pixels) from the SDRAM controller read port in bursts into a show-ahead
//   FIFO, and hands one word to the LCD pixel driver per pop request.
//   A frame restart pulse rewinds the read pointer to FRAME_BASE.
//
// Ports
//   i_clk_lcd       pixel clock, all logic on the rising edge
//   i_lcd_rst       synchronous active-high reset
//   i_sdr_addr_set  one-cycle frame restart pulse
//   i_lcd_rden      pop request, one word per cycle high
//   o_lcd_data      FIFO head word
//   o_rd_req        burst read request (held until i_rd_ack)
//   o_rd_addr       burst start address, valid while o_rd_req
//   o_rd_len        burst length in words, valid while o_rd_req
//   i_rd_ack        controller accepts the request
//   i_rd_valid      read data beat valid
//   i_rd_data       read data beat
//   o_fifo_level    current FIFO occupancy
//   o_underflow     sticky, pop attempted on an empty FIFO
//
// FSM
//   state  | meaning
//   S_IDLE | waiting for free space / frame words left; performs restart flush
//   S_REQ  | o_rd_req high, address and length held until acknowledged
//   S_DATA | collecting rd_len beats (discarded while a restart is pending)

module lcd_frame_reader #(
    parameter int FRAME_BASE  = 0,
    parameter int FRAME_WORDS = 32640,
    parameter int BURST_LEN   = 8,
    parameter int FIFO_DEPTH  = 32,
    parameter int ADDR_W      = 22
) (
    input  logic                          i_clk_lcd,
    input  logic                          i_lcd_rst,
    input  logic                          i_sdr_addr_set,
    input  logic                          i_lcd_rden,
    output logic [95:0]                   o_lcd_data,
    output logic                          o_rd_req,
    output logic [ADDR_W-1:0]             o_rd_addr,
    output logic [$clog2(BURST_LEN):0]    o_rd_len,
    input  logic                          i_rd_ack,
    input  logic                          i_rd_valid,
    input  logic [95:0]                   i_rd_data,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
    output logic                          o_underflow
);

    localparam int LEN_W = $clog2(BURST_LEN) + 1;
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FRAME_WORDS + 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DATA} state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [CNT_W-1:0]   r_issued;
    logic               r_restart_pend;
    logic [ADDR_W-1:0]  r_rd_addr;
    logic [LEN_W-1:0]   r_rd_len;
    logic [LEN_W-1:0]   r_beats_left;

    logic [95:0]        r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [LVL_W-1:0]   r_level;
    logic [95:0]        r_head;
    logic               r_underflow;

    logic [31:0]        w_remaining;
    logic [31:0]        w_free;
    logic               w_can_issue;
    logic [LEN_W-1:0]   w_next_len;
    logic               w_flush;
    logic               w_push;
    logic               w_pop;
    logic               w_last_beat;

    assign w_remaining = 32'(FRAME_WORDS) - 32'(r_issued);
    assign w_free      = 32'(FIFO_DEPTH) - 32'(r_level);
    // Free space is only judged in IDLE, where no beats are outstanding,
    // so a granted burst always fits.
    assign w_can_issue = !r_restart_pend && (w_remaining != 32'd0) &&
                         (w_free >= 32'(BURST_LEN));
    assign w_next_len  = (w_remaining >= 32'(BURST_LEN)) ? LEN_W'(BURST_LEN)
                                                         : LEN_W'(w_remaining);
    assign w_flush     = (r_state == S_IDLE) && r_restart_pend;
    // A restart arriving mid-burst drops that beat and all later ones.
    assign w_push      = (r_state == S_DATA) && i_rd_valid &&
                         !r_restart_pend && !i_sdr_addr_set;
    assign w_last_beat = (r_state == S_DATA) && i_rd_valid &&
                         (r_beats_left == LEN_W'(1));
    assign w_pop       = i_lcd_rden && (r_level != '0) && !w_flush;

    always_ff @(posedge i_clk_lcd) begin
        if (i_lcd_rst) r_state <= S_IDLE;
        else           r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_can_issue) w_state_next = S_REQ;
            S_REQ:   if (i_rd_ack)    w_state_next = S_DATA;
            S_DATA:  if (w_last_beat) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk_lcd) begin
        if (i_lcd_rst) begin
            r_issued       <= '0;
            r_restart_pend <= 1'b0;
            r_rd_addr      <= ADDR_W'(FRAME_BASE);
            r_rd_len       <= '0;
            r_beats_left   <= '0;
        end else begin
            if (r_state == S_IDLE && w_can_issue) begin
                r_rd_addr <= ADDR_W'(FRAME_BASE) + ADDR_W'(r_issued);
                r_rd_len  <= w_next_len;
            end
            if (r_state == S_REQ && i_rd_ack) begin
                r_issued     <= r_issued + CNT_W'(r_rd_len);
                r_beats_left <= r_rd_len;
            end else if (r_state == S_DATA && i_rd_valid) begin
                r_beats_left <= r_beats_left - LEN_W'(1);
            end
            if (w_flush) begin
                r_issued       <= '0;
                r_restart_pend <= 1'b0;
            end else if (i_sdr_addr_set) begin
                r_restart_pend <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk_lcd) begin
        if (w_push) r_mem[r_wr_ptr] <= i_rd_data;
    end

    // r_head is a registered copy of the FIFO head so lcd_data can be
    // cleared on flush and holds its last word once the FIFO runs dry.
    always_ff @(posedge i_clk_lcd) begin
        if (i_lcd_rst || w_flush) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_head      <= '0;
            r_underflow <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
            if (w_push && (r_level == '0 || (w_pop && r_level == LVL_W'(1))))
                r_head <= i_rd_data;
            else if (w_pop && r_level > LVL_W'(1))
                r_head <= r_mem[r_rd_ptr + PTR_W'(1)];
            if (i_lcd_rden && r_level == '0)
                r_underflow <= 1'b1;
        end
    end

    assign o_rd_req     = (r_state == S_REQ);
    assign o_rd_addr    = r_rd_addr;
    assign o_rd_len     = r_rd_len;
    assign o_lcd_data   = r_head;
    assign o_fifo_level = r_level;
    assign o_underflow  = r_underflow;

endmodule

// File: tb/tb_lcd_frame_reader.sv
// Directed bench for lcd_frame_reader: dut_a uses the default frame size,
// dut_b a 20-word frame to exercise the short final burst and end of frame.

module tb_lcd_frame_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        a_set, a_rden, a_ack, a_valid;
    logic [95:0] a_wdata;
    logic [95:0] a_data;
    logic        a_req;
    logic [21:0] a_addr;
    logic [3:0]  a_len;
    logic [5:0]  a_level;
    logic        a_uf;

    logic        b_set, b_rden, b_ack, b_valid;
    logic [95:0] b_wdata;
    logic [95:0] b_data;
    logic        b_req;
    logic [21:0] b_addr;
    logic [3:0]  b_len;
    logic [5:0]  b_level;
    logic        b_uf;

    int n_checks = 0;
    int n_errors = 0;

    lcd_frame_reader dut_a (
        .i_clk_lcd(clk), .i_lcd_rst(rst), .i_sdr_addr_set(a_set),
        .i_lcd_rden(a_rden), .o_lcd_data(a_data), .o_rd_req(a_req),
        .o_rd_addr(a_addr), .o_rd_len(a_len), .i_rd_ack(a_ack),
        .i_rd_valid(a_valid), .i_rd_data(a_wdata), .o_fifo_level(a_level),
        .o_underflow(a_uf)
    );

    lcd_frame_reader #(.FRAME_WORDS(20)) dut_b (
        .i_clk_lcd(clk), .i_lcd_rst(rst), .i_sdr_addr_set(b_set),
        .i_lcd_rden(b_rden), .o_lcd_data(b_data), .o_rd_req(b_req),
        .o_rd_addr(b_addr), .o_rd_len(b_len), .i_rd_ack(b_ack),
        .i_rd_valid(b_valid), .i_rd_data(b_wdata), .o_fifo_level(b_level),
        .o_underflow(b_uf)
    );

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [95:0] pat(input int k);
        logic [15:0] s;
        s = k[15:0];
        return {16'hC0DE, s, 32'h1234_5678, 16'hBEEF, s};
    endfunction

    task tick;
        @(negedge clk);
    endtask

    task automatic wait_req_a(input string tag, input int budget);
        int c = 0;
        while (a_req !== 1'b1 && c < budget) begin
            tick();
            c++;
        end
        chk(tag, 96'(a_req), 96'd1);
    endtask

    task automatic wait_req_b(input string tag, input int budget);
        int c = 0;
        while (b_req !== 1'b1 && c < budget) begin
            tick();
            c++;
        end
        chk(tag, 96'(b_req), 96'd1);
    endtask

    task automatic serve_a(input int exp_addr, input int exp_len, input bit chk_first);
        wait_req_a("a_req_seen", 20);
        chk("a_rd_addr", 96'(a_addr), 96'(exp_addr));
        chk("a_rd_len", 96'(a_len), 96'(exp_len));
        a_ack = 1'b1;
        tick();
        a_ack = 1'b0;
        chk("a_req_drop", 96'(a_req), 96'd0);
        for (int i = 0; i < exp_len; i++) begin
            a_valid = 1'b1;
            a_wdata = pat(exp_addr + i);
            tick();
            if (chk_first && i == 0) chk("a_first_word", a_data, pat(exp_addr));
        end
        a_valid = 1'b0;
    endtask

    task automatic serve_b(input int exp_addr, input int exp_len);
        wait_req_b("b_req_seen", 20);
        chk("b_rd_addr", 96'(b_addr), 96'(exp_addr));
        chk("b_rd_len", 96'(b_len), 96'(exp_len));
        b_ack = 1'b1;
        tick();
        b_ack = 1'b0;
        for (int i = 0; i < exp_len; i++) begin
            b_valid = 1'b1;
            b_wdata = pat(1000 + exp_addr + i);
            tick();
        end
        b_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit seen;
        rst = 1'b1;
        a_set = 0; a_rden = 0; a_ack = 0; a_valid = 0; a_wdata = '0;
        b_set = 0; b_rden = 0; b_ack = 0; b_valid = 0; b_wdata = '0;
        repeat (3) tick();

        // reset values
        chk("rst_rd_req", 96'(a_req), 96'd0);
        chk("rst_rd_addr", 96'(a_addr), 96'd0);
        chk("rst_rd_len", 96'(a_len), 96'd0);
        chk("rst_lcd_data", a_data, 96'd0);
        chk("rst_level", 96'(a_level), 96'd0);
        chk("rst_underflow", 96'(a_uf), 96'd0);
        chk("rst_b_rd_req", 96'(b_req), 96'd0);
        rst = 1'b0;

        // fill: four bursts at 0, 8, 16, 24
        serve_a(0, 8, 1'b1);
        chk("a_level_8", 96'(a_level), 96'd8);
        serve_a(8, 8, 1'b0);
        serve_a(16, 8, 1'b0);
        serve_a(24, 8, 1'b0);
        chk("a_level_32", 96'(a_level), 96'd32);
        seen = 1'b0;
        repeat (6) begin
            tick();
            if (a_req !== 1'b0) seen = 1'b1;
        end
        chk("a_full_no_req", 96'(seen), 96'd0);

        // pop 8, refill request at 32
        for (int i = 0; i < 8; i++) begin
            chk("a_pop_order", a_data, pat(i));
            a_rden = 1'b1;
            tick();
        end
        a_rden = 1'b0;
        chk("a_level_24", 96'(a_level), 96'd24);
        wait_req_a("a_refill_req", 2);
        serve_a(32, 8, 1'b0);
        chk("a_level_32b", 96'(a_level), 96'd32);

        // drain to 5 while the next request (addr 40) stays pending
        for (int i = 0; i < 27; i++) begin
            chk("a_pop_order2", a_data, pat(8 + i));
            a_rden = 1'b1;
            tick();
        end
        a_rden = 1'b0;
        chk("a_level_5", 96'(a_level), 96'd5);
        wait_req_a("a_req40_seen", 2);
        chk("a_req40_addr", 96'(a_addr), 96'd40);

        // simultaneous push and pop at level 5
        a_ack = 1'b1;
        tick();
        a_ack = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("a_pp_order", a_data, pat(35 + i));
            a_valid = 1'b1;
            a_wdata = pat(40 + i);
            a_rden  = 1'b1;
            tick();
            chk("a_pp_level", 96'(a_level), 96'd5);
        end
        a_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("a_pp_tail", a_data, pat(43 + i));
            tick();
        end
        a_rden = 1'b0;
        chk("a_level_0", 96'(a_level), 96'd0);
        chk("a_uf_before", 96'(a_uf), 96'd0);

        // underflow
        a_rden = 1'b1;
        tick();
        a_rden = 1'b0;
        chk("a_uf_set", 96'(a_uf), 96'd1);
        chk("a_uf_level", 96'(a_level), 96'd0);
        chk("a_uf_data_hold", a_data, pat(47));

        // restart after beat 3 of the burst at 48
        wait_req_a("a_req48_seen", 3);
        chk("a_req48_addr", 96'(a_addr), 96'd48);
        a_ack = 1'b1;
        tick();
        a_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a_valid = 1'b1;
            a_wdata = pat(48 + i);
            tick();
        end
        a_valid = 1'b0;
        chk("a_rs_level3", 96'(a_level), 96'd3);
        a_rden = 1'b1;
        tick();
        a_rden = 1'b0;
        chk("a_rs_level2", 96'(a_level), 96'd2);
        chk("a_uf_sticky", 96'(a_uf), 96'd1);
        chk("a_rs_head", a_data, pat(49));
        a_set = 1'b1;
        tick();
        a_set = 1'b0;
        for (int i = 3; i < 8; i++) begin
            a_valid = 1'b1;
            a_wdata = pat(48 + i);
            tick();
        end
        a_valid = 1'b0;
        chk("a_rs_discard", 96'(a_level), 96'd2);
        tick();
        chk("a_flush_level", 96'(a_level), 96'd0);
        chk("a_flush_data", a_data, 96'd0);
        chk("a_flush_uf", 96'(a_uf), 96'd0);
        serve_a(0, 8, 1'b1);
        chk("a_after_rs_level", 96'(a_level), 96'd8);

        // short frame: 8, 8, 4 then stop
        serve_b(0, 8);
        serve_b(8, 8);
        serve_b(16, 4);
        chk("b_level_20", 96'(b_level), 96'd20);
        seen = 1'b0;
        repeat (10) begin
            tick();
            if (b_req !== 1'b0) seen = 1'b1;
        end
        chk("b_eof_no_req", 96'(seen), 96'd0);
        chk("b_head", b_data, pat(1000));
        b_set = 1'b1;
        tick();
        b_set = 1'b0;
        wait_req_b("b_rs_req", 5);
        chk("b_rs_addr", 96'(b_addr), 96'd0);
        chk("b_rs_len", 96'(b_len), 96'd8);
        chk("b_rs_level", 96'(b_level), 96'd0);

        // restart while request is pending: never withdrawn, beats dropped
        b_set = 1'b1;
        tick();
        b_set = 1'b0;
        chk("b_req_held", 96'(b_req), 96'd1);
        b_ack = 1'b1;
        tick();
        b_ack = 1'b0;
        for (int i = 0; i < 8; i++) begin
            b_valid = 1'b1;
            b_wdata = pat(2000 + i);
            tick();
        end
        b_valid = 1'b0;
        chk("b_req_rs_discard", 96'(b_level), 96'd0);
        wait_req_b("b_req_after_rs", 5);
        chk("b_req_after_rs_addr", 96'(b_addr), 96'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
